// File: rtl/rom_loader.sv
// Boot-time image loader. Accepts a little-endian length-prefixed byte stream,
// writes the payload into the ROM write port from address 0, then writes the
// 6502 reset vector into ROM[SIZE-4]/ROM[SIZE-3]. It then holds the CPU in reset
// for HOLD_CYCLES cycles before releasing it. All outputs are registered.
module rom_loader #(
    parameter int          ADDR_W      = 12,
    parameter logic [15:0] RESET_VEC   = 16'hF000,
    parameter int          HOLD_CYCLES = 8
) (
    input  logic              ph2,
    input  logic              reset_b,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int SIZE = 2 ** ADDR_W;
    // The largest legal payload stops short of the reset-vector bytes, so the
    // payload address counter can never reach them.
    localparam logic [15:0]       MAX_LEN     = 16'(SIZE - 4);
    localparam logic [ADDR_W-1:0] VEC_LO_ADDR = ADDR_W'(SIZE - 4);
    localparam logic [ADDR_W-1:0] VEC_HI_ADDR = ADDR_W'(SIZE - 3);
    localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_VEC_LO = 3'd4,
        S_VEC_HI = 3'd5,
        S_HOLD   = 3'd6,
        S_RUN    = 3'd7
    } state_t;

    state_t            state_r;
    logic              err_state_r;   // ERR is tracked separately so all 8 codes stay meaningful
    logic [7:0]        len_lo_r;
    logic [ADDR_W-1:0] count_r;
    logic [ADDR_W-1:0] last_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    logic              xfer_s;
    logic [15:0]       len_s;

    // Handshake and assembled length, valid while LEN_HI is being accepted.
    always_comb begin
        xfer_s = in_valid & in_ready;
        len_s  = {in_data, len_lo_r};
    end

    // Loader FSM with registered outputs; rom_we is a one-cycle strobe by default.
    always_ff @(posedge ph2 or negedge reset_b) begin
        if (!reset_b) begin
            state_r     <= S_IDLE;
            err_state_r <= 1'b0;
            len_lo_r    <= 8'h00;
            count_r     <= '0;
            last_r      <= '0;
            hold_cnt_r  <= '0;
            in_ready    <= 1'b0;
            rom_we      <= 1'b0;
            rom_addr    <= '0;
            rom_wdata   <= 8'h00;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            rom_we <= 1'b0;
            if (err_state_r) begin
                // Rejected length: wait for a fresh start, nothing else happens.
                if (start) begin
                    err_state_r <= 1'b0;
                    state_r     <= S_LEN_LO;
                    err         <= 1'b0;
                    busy        <= 1'b1;
                    in_ready    <= 1'b1;
                end
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (start) begin
                            state_r  <= S_LEN_LO;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                    S_LEN_LO: begin
                        if (xfer_s) begin
                            len_lo_r <= in_data;
                            state_r  <= S_LEN_HI;
                        end
                    end
                    S_LEN_HI: begin
                        if (xfer_s) begin
                            if (len_s > MAX_LEN) begin
                                err_state_r <= 1'b1;
                                err         <= 1'b1;
                                busy        <= 1'b0;
                                in_ready    <= 1'b0;
                            end else if (len_s == 16'd0) begin
                                state_r  <= S_VEC_LO;
                                in_ready <= 1'b0;
                            end else begin
                                state_r <= S_DATA;
                                count_r <= '0;
                                last_r  <= ADDR_W'(len_s - 16'd1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (xfer_s) begin
                            rom_we    <= 1'b1;
                            rom_addr  <= count_r;
                            rom_wdata <= in_data;
                            count_r   <= count_r + ADDR_W'(1);
                            if (count_r == last_r) begin
                                state_r  <= S_VEC_LO;
                                in_ready <= 1'b0;
                            end
                        end
                    end
                    S_VEC_LO: begin
                        rom_we    <= 1'b1;
                        rom_addr  <= VEC_LO_ADDR;
                        rom_wdata <= RESET_VEC[7:0];
                        state_r   <= S_VEC_HI;
                    end
                    S_VEC_HI: begin
                        rom_we     <= 1'b1;
                        rom_addr   <= VEC_HI_ADDR;
                        rom_wdata  <= RESET_VEC[15:8];
                        hold_cnt_r <= '0;
                        state_r    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_cnt_r == HOLD_MAX) begin
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_r   <= S_RUN;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        end
                    end
                    S_RUN: begin
                        state_r <= S_RUN;
                    end
                    default: begin
                        state_r   <= S_IDLE;
                        in_ready  <= 1'b0;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of load scenarios plus hand-written
// sequences for reset during idle, reset mid-payload and start while running.
module tb_rom_loader;

    logic        ph2 = 1'b0;
    logic        reset_b;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        rom_we;
    logic [11:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int we_cnt = 0;
    int last_k = 0;
    logic [7:0] rom_m [0:4095];

    rom_loader dut (
        .ph2(ph2), .reset_b(reset_b), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .rom_we(rom_we),
        .rom_addr(rom_addr), .rom_wdata(rom_wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .err(err)
    );

    always #5 ph2 = ~ph2;

    // Edge counter and ROM model capturing every write strobe.
    always @(posedge ph2) begin
        cyc <= cyc + 1;
        if (rom_we === 1'b1) begin
            rom_m[rom_addr] <= rom_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    typedef struct packed {
        logic [31:0] n;
        logic [63:0] bytes;
        logic        gaps;
        logic        from_err;
        logic        exp_err;
        logic [31:0] exp_we;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_outs"},
            {20'd0, in_ready, rom_we, busy, done, err, cpu_reset, 6'd0},
            {20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
        chk({tag, "_addr_data"}, {12'd0, rom_addr, rom_wdata}, 32'd0);
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge ph2); #1;
        reset_b = 1'b1;
        @(posedge ph2); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge ph2); #1;
        start = 1'b0;
    endtask

    // Offers one byte after g idle cycles; returns once it was accepted.
    task automatic send_byte(input logic [7:0] b, input int g);
        int t;
        in_valid = 1'b0;
        repeat (g) begin @(posedge ph2); #1; end
        in_valid = 1'b1;
        in_data = b;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge ph2); #1; t++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge ph2); #1;
        last_k = cyc;
        in_valid = 1'b0;
    endtask

    // Waits for done or err; in_ready must stay low meanwhile (VEC/HOLD).
    task automatic wait_end(output int ev);
        int t;
        t = 0;
        while (!done && !err && t < 60) begin
            chk("in_ready_hold", {31'd0, in_ready}, 32'd0);
            @(posedge ph2); #1; t++;
        end
        ev = cyc;
    endtask

    task automatic check_image();
        chk("rom0", {24'd0, rom_m[0]}, 32'h0000_00A9);
        chk("rom1", {24'd0, rom_m[1]}, 32'h0000_00AA);
        chk("rom2", {24'd0, rom_m[2]}, 32'h0000_0085);
        chk("rom_veclo", {24'd0, rom_m[4092]}, 32'h0000_0000);
        chk("rom_vechi", {24'd0, rom_m[4093]}, 32'h0000_00F0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base, k, g, ev;
        logic [7:0] bt;
        if (!v.from_err) do_reset();
        chk($sformatf("v%0d_idle_ready", idx), {31'd0, in_ready}, 32'd0);
        base = we_cnt;
        pulse_start();
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        for (int i = 0; i < int'(v.n); i++) begin
            g = v.gaps ? int'($urandom_range(0, 2)) : 0;
            bt = v.bytes[8*i +: 8];
            send_byte(bt, g);
        end
        k = last_k;
        chk($sformatf("v%0d_ready_after_last", idx), {31'd0, in_ready}, 32'd0);
        wait_end(ev);
        if (v.exp_err) begin
            chk($sformatf("v%0d_err_flags", idx), {28'd0, err, done, busy, cpu_reset}, 32'b1001);
            chk($sformatf("v%0d_err_edge", idx), ev, k);
        end else begin
            chk($sformatf("v%0d_done_flags", idx), {28'd0, err, done, busy, cpu_reset}, 32'b0100);
            chk($sformatf("v%0d_done_edge", idx), ev, k + 11);
            chk($sformatf("v%0d_run_ready", idx), {31'd0, in_ready}, 32'd0);
            chk($sformatf("v%0d_veclo", idx), {24'd0, rom_m[4092]}, 32'h0000_0000);
            chk($sformatf("v%0d_vechi", idx), {24'd0, rom_m[4093]}, 32'h0000_00F0);
            for (int i = 2; i < int'(v.n); i++) begin
                chk($sformatf("v%0d_rom%0d", idx, i - 2), {24'd0, rom_m[i - 2]},
                    {24'd0, v.bytes[8*i +: 8]});
            end
        end
        chk($sformatf("v%0d_we_pulses", idx), we_cnt - base, v.exp_we);
    endtask

    initial begin
        vec_t vecs [5];
        int base, ev;
        // bytes packed with the first stream byte in the low octet
        vecs[0] = '{32'd5, 64'h0000_0085_AAA9_0003, 1'b0, 1'b0, 1'b0, 32'd5};
        vecs[1] = '{32'd5, 64'h0000_0085_AAA9_0003, 1'b1, 1'b0, 1'b0, 32'd5};
        vecs[2] = '{32'd2, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 32'd2};
        vecs[3] = '{32'd2, 64'h0000_0000_0000_0FFD, 1'b0, 1'b0, 1'b1, 32'd0};
        vecs[4] = '{32'd5, 64'h0000_0085_AAA9_0003, 1'b0, 1'b1, 1'b0, 32'd5};

        reset_b = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        // Reset held while inputs toggle randomly.
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); in_valid = 1'($urandom); in_data = 8'($urandom);
            @(posedge ph2); #1;
            check_reset_vals("rst_hold");
        end
        start = 1'b0; in_valid = 1'b0;
        #2 reset_b = 1'b1;
        @(posedge ph2); #1;
        check_reset_vals("idle");

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // start while running is ignored.
        base = we_cnt;
        pulse_start();
        repeat (3) begin @(posedge ph2); #1; end
        chk("run_start_ignored", {29'd0, done, busy, cpu_reset}, 32'b100);
        chk("run_no_writes", we_cnt - base, 32'd0);

        // Reset mid-payload: L=10, 5 bytes sent, then async reset between edges.
        do_reset();
        pulse_start();
        send_byte(8'h0A, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + 8'(i)), 0);
        #2 reset_b = 1'b0;
        #1 check_reset_vals("mid_reset");
        @(posedge ph2); #1;
        check_reset_vals("mid_reset_held");
        reset_b = 1'b1;
        @(posedge ph2); #1;
        base = we_cnt;
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA9, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h85, 0);
        wait_end(ev);
        chk("reload_done_edge", ev, last_k + 11);
        chk("reload_flags", {29'd0, done, cpu_reset, err}, 32'b100);
        chk("reload_pulses", we_cnt - base, 32'd5);
        check_image();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
